// File: rtl/histo_ingest_arbiter.sv
// histo_ingest_arbiter: round-robin sharing of the histogram core write port
// through a one-entry hold buffer, plus a dump-frame readout monitor.
module histo_ingest_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2,
    parameter int FCNT_W  = 16
) (
    input  logic                  clk,
    input  logic                  bin_reset,
    input  logic [NUM_REQ-1:0]    req_valid,
    input  logic [16*NUM_REQ-1:0] req_data,
    input  logic [NUM_REQ-1:0]    req_enable,
    output logic [NUM_REQ-1:0]    req_ready,
    output logic [15:0]           hist_data_in,
    output logic                  hist_write_en,
    input  logic                  hist_ready,
    input  logic                  hist_valid_out,
    input  logic                  hist_last_bin,
    output logic [ID_W-1:0]       grant_id,
    output logic                  dumping,
    output logic [FCNT_W-1:0]     frame_count,
    output logic                  frame_err
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } buf_state_t;

    localparam int              BEAT_W      = 7;
    localparam logic [BEAT_W-1:0] FRAME_BEATS = 7'd64;
    localparam logic [ID_W-1:0] PTR_RST     = ID_W'(NUM_REQ - 1);
    localparam logic [ID_W:0]   NREQ_X      = (ID_W + 1)'(NUM_REQ);

    buf_state_t         state;
    logic [ID_W-1:0]    rr_ptr;
    logic [NUM_REQ-1:0] masked;
    logic               consume;
    logic               can_accept;
    logic               gnt_found;
    logic [ID_W-1:0]    gnt_idx;
    logic [ID_W:0]      cand;
    logic               load;

    logic [BEAT_W-1:0]  beat;
    logic [BEAT_W-1:0]  beat_nxt;

    assign masked     = req_valid & req_enable;
    assign consume    = (state == FULL) && hist_ready;
    assign can_accept = !bin_reset && ((state == EMPTY) || consume);
    assign load       = can_accept && gnt_found;

    assign hist_write_en = (state == FULL);
    assign dumping       = ~hist_ready;

    // Scan from far to near so the nearest set bit after rr_ptr wins.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        cand      = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            cand = {1'b0, rr_ptr} + (ID_W + 1)'(k);
            if (cand >= NREQ_X)
                cand = cand - NREQ_X;
            if (masked[cand[ID_W-1:0]]) begin
                gnt_found = 1'b1;
                gnt_idx   = cand[ID_W-1:0];
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (load)
            req_ready[gnt_idx] = 1'b1;
    end

    always_ff @(posedge clk or posedge bin_reset) begin
        if (bin_reset) begin
            state        <= EMPTY;
            rr_ptr       <= PTR_RST;
            hist_data_in <= '0;
            grant_id     <= '0;
        end else if (load) begin
            state        <= FULL;
            rr_ptr       <= gnt_idx;
            grant_id     <= gnt_idx;
            hist_data_in <= req_data[16*gnt_idx +: 16];
        end else if (consume) begin
            state        <= EMPTY;
        end
    end

    assign beat_nxt = beat + 1'b1;

    // A good frame is exactly 64 valid beats with last_bin on the 64th.
    always_ff @(posedge clk or posedge bin_reset) begin
        if (bin_reset) begin
            beat        <= '0;
            frame_count <= '0;
            frame_err   <= 1'b0;
        end else if (hist_valid_out && hist_last_bin) begin
            beat <= '0;
            if (beat_nxt == FRAME_BEATS) begin
                if (frame_count != '1)
                    frame_count <= frame_count + 1'b1;
            end else begin
                frame_err <= 1'b1;
            end
        end else if (hist_valid_out) begin
            if (beat == FRAME_BEATS) begin
                frame_err <= 1'b1;
                beat      <= '0;
            end else begin
                beat      <= beat_nxt;
            end
        end else if (hist_last_bin) begin
            frame_err <= 1'b1;
            beat      <= '0;
        end
    end

endmodule

// File: tb/tb_histo_ingest_arbiter.sv
// tb_histo_ingest_arbiter: directed scenarios plus random traffic checked
// against a queue/arithmetic reference model of arbiter and frame monitor.
module tb_histo_ingest_arbiter;

    localparam int N = 4;

    logic            clk = 1'b0;
    logic            bin_reset;
    logic [N-1:0]    req_valid;
    logic [16*N-1:0] req_data;
    logic [N-1:0]    req_enable;
    logic [N-1:0]    req_ready;
    logic [15:0]     hist_data_in;
    logic            hist_write_en;
    logic            hist_ready;
    logic            hist_valid_out;
    logic            hist_last_bin;
    logic [1:0]      grant_id;
    logic            dumping;
    logic [15:0]     frame_count;
    logic            frame_err;

    logic [15:0] d [N];

    int tests = 0;
    int fails = 0;

    bit          m_full;
    logic [15:0] m_data;
    int          m_id;
    int          m_last;
    int          m_beats;
    int          m_fc;
    bit          m_err;
    logic [N-1:0] m_rdy;

    always #5 clk = ~clk;

    always_comb
        for (int i = 0; i < N; i++)
            req_data[16*i +: 16] = d[i];

    histo_ingest_arbiter #(.NUM_REQ(N), .ID_W(2), .FCNT_W(16)) dut (
        .clk(clk), .bin_reset(bin_reset),
        .req_valid(req_valid), .req_data(req_data),
        .req_enable(req_enable), .req_ready(req_ready),
        .hist_data_in(hist_data_in), .hist_write_en(hist_write_en),
        .hist_ready(hist_ready), .hist_valid_out(hist_valid_out),
        .hist_last_bin(hist_last_bin), .grant_id(grant_id),
        .dumping(dumping), .frame_count(frame_count),
        .frame_err(frame_err)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int rr_pick(input logic [N-1:0] c, input int last);
        for (int k = 1; k <= N; k++)
            if (c[(last + k) % N]) return (last + k) % N;
        return -1;
    endfunction

    task automatic model_reset();
        m_full = 0; m_data = '0; m_id = 0; m_last = N - 1;
        m_beats = 0; m_fc = 0; m_err = 0;
    endtask

    task automatic check_regs();
        check("write_en", hist_write_en, m_full);
        check("data_in", hist_data_in, m_data);
        check("grant_id", grant_id, m_id);
        check("frame_count", frame_count, m_fc);
        check("frame_err", frame_err, m_err);
    endtask

    // One clock: check comb outputs, advance model at the edge, check regs.
    task automatic cyc();
        int g;
        int n;
        #1;
        g = (!bin_reset && (!m_full || hist_ready))
            ? rr_pick(req_valid & req_enable, m_last) : -1;
        m_rdy = '0;
        if (g >= 0) m_rdy[g] = 1'b1;
        check("req_ready", req_ready, m_rdy);
        check("dumping", dumping, !hist_ready);
        @(posedge clk);
        if (bin_reset) begin
            model_reset();
        end else begin
            if (g >= 0) begin
                m_full = 1; m_data = d[g]; m_id = g; m_last = g;
            end else if (m_full && hist_ready) begin
                m_full = 0;
            end
            if (hist_valid_out) begin
                n = m_beats + 1;
                if (hist_last_bin) begin
                    if (n == 64) m_fc = (m_fc == 65535) ? m_fc : m_fc + 1;
                    else m_err = 1;
                    m_beats = 0;
                end else if (n > 64) begin
                    m_err = 1; m_beats = 0;
                end else begin
                    m_beats = n;
                end
            end else if (hist_last_bin) begin
                m_err = 1; m_beats = 0;
            end
        end
        #1;
        check_regs();
    endtask

    task automatic refill(input int pct);
        for (int i = 0; i < N; i++) begin
            if (m_rdy[i]) begin
                req_valid[i] = ($urandom_range(99) < pct);
                d[i] = 16'($urandom);
            end else if (!req_valid[i] && $urandom_range(99) < pct) begin
                req_valid[i] = 1'b1;
                d[i] = 16'($urandom);
            end
        end
    endtask

    task automatic do_reset();
        bin_reset = 1'b1;
        req_valid = '0;
        hist_valid_out = 0; hist_last_bin = 0; hist_ready = 1;
        cyc();
        bin_reset = 1'b0;
    endtask

    task automatic frame(input int beats, input int last_at);
        for (int b = 1; b <= beats; b++) begin
            hist_valid_out = 1'b1;
            hist_last_bin  = (b == last_at);
            cyc();
        end
        hist_valid_out = 0; hist_last_bin = 0;
    endtask

    initial begin
        bin_reset = 1; req_valid = '0; req_enable = '1;
        hist_ready = 1; hist_valid_out = 0; hist_last_bin = 0;
        for (int i = 0; i < N; i++) d[i] = '0;
        model_reset();
        #12;
        check("rst_write_en", hist_write_en, 0);
        check("rst_data", hist_data_in, 0);
        check("rst_gid", grant_id, 0);
        check("rst_fc", frame_count, 0);
        check("rst_err", frame_err, 0);
        @(negedge clk);
        bin_reset = 0;

        // alternating two requesters at full throughput
        req_valid = 4'b0101; d[0] = 16'hA000; d[2] = 16'hB000;
        for (int c = 0; c < 8; c++) begin
            cyc();
            check("t1_gid", grant_id, (c % 2) ? 2 : 0);
            check("t1_wen", hist_write_en, 1);
            for (int i = 0; i < N; i++) if (m_rdy[i]) d[i] = d[i] + 1'b1;
        end

        // masked requester never granted
        do_reset();
        req_enable = 4'b1011; req_valid = 4'b1111;
        for (int c = 0; c < 4; c++) begin
            cyc();
            check("t3_gid", grant_id, (c == 2) ? 3 : (c == 3) ? 0 : c);
        end
        req_enable = '1;

        // 256 writes then a dump; next sample held through the readout
        do_reset();
        req_valid = 4'b0010;
        for (int c = 0; c < 257; c++) begin
            d[1] = (c < 256) ? 16'h0003 : 16'h0004;
            cyc();
        end
        req_valid = '0; hist_ready = 0;
        for (int b = 1; b <= 66; b++) begin
            hist_valid_out = (b <= 64);
            hist_last_bin  = (b == 64);
            cyc();
            check("t2_hold", hist_data_in, 16'h0004);
        end
        hist_valid_out = 0; hist_last_bin = 0; hist_ready = 1;
        cyc();
        check("t2_drain", hist_write_en, 0);
        check("t2_fc", frame_count, 1);
        check("t2_err", frame_err, 0);

        // short frame flags an error; later good frame still counted
        do_reset();
        frame(10, 10);
        check("t4_err", frame_err, 1);
        check("t4_fc", frame_count, 0);
        frame(64, 64);
        check("t4_fc2", frame_count, 1);
        check("t4_err2", frame_err, 1);

        // asynchronous reset mid-dump with the buffer full
        req_valid = 4'b0100; d[2] = 16'h5A5A;
        cyc();
        req_valid = '0; hist_ready = 0;
        frame(5, 0);
        #2 bin_reset = 1;
        #1;
        check("t5_wen", hist_write_en, 0);
        check("t5_fc", frame_count, 0);
        check("t5_err", frame_err, 0);
        check("t5_data", hist_data_in, 0);
        model_reset();
        hist_ready = 1;
        cyc();
        bin_reset = 0;
        req_valid = 4'b1111;
        cyc();
        check("t5_first", grant_id, 0);

        // idle
        do_reset();
        for (int c = 0; c < 20; c++) begin
            cyc();
            check("t6_wen", hist_write_en, 0);
        end

        // random traffic
        for (int c = 0; c < 2000; c++) begin
            refill(40);
            if ($urandom_range(15) == 0) req_enable = 4'($urandom);
            hist_ready = ($urandom_range(7) != 0);
            hist_valid_out = $urandom_range(1);
            hist_last_bin = hist_valid_out
                ? ((m_beats == 63 && $urandom_range(7) != 0) || $urandom_range(63) == 0)
                : ($urandom_range(127) == 0);
            bin_reset = ($urandom_range(299) == 0);
            cyc();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
